// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_pkg
// Description : Shared AXI encodings, engine state types and beat helper for
//               the SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    localparam logic [63:0] BEAT_BYTES  = 64'd8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                   input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + BEAT_BYTES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : axi_lfsr8
// Description : 8-bit Galois LFSR (right shift, tap mask TAPS) with enable.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5,
    parameter logic [7:0] TAPS = 8'hB8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_enable,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SEED;
        end else if (i_enable) begin
            r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/axi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_responder
// Description : AXI4-subset responder over a 64-bit word array with
//               independent read/write engines. Optional random handshake
//               stalls when AXI_SRAM_RAND_STALL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter logic [63:0] BASE   = 64'h8000_0000,
    parameter int          DEPTH  = 4096,
    parameter int          RD_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ar_valid,
    output logic        ar_ready,
    input  logic [63:0] ar_addr,
    input  logic [7:0]  ar_len,
    input  logic [2:0]  ar_size,
    input  logic [1:0]  ar_burst,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [63:0] r_rdata,
    output logic [1:0]  r_resp,
    output logic        r_last,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [63:0] aw_addr,
    input  logic [7:0]  aw_len,
    input  logic [2:0]  aw_size,
    input  logic [1:0]  aw_burst,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [63:0] w_data,
    input  logic [7:0]  w_strb,
    input  logic        w_last,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [1:0]  b_resp
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [63:0] c_SPAN     = 64'(DEPTH) * BEAT_BYTES;
    localparam logic [7:0]  c_LAT_INIT = 8'(RD_LAT - 1);

    logic [63:0] r_mem [DEPTH];

    function automatic logic f_in_range(input logic [63:0] addr);
        return (addr >= BASE) && ((addr - BASE) < c_SPAN);
    endfunction

    function automatic logic [c_AW-1:0] f_index(input logic [63:0] addr);
        return c_AW'((addr - BASE) >> 3);
    endfunction

    // WRAP and the reserved encoding both have bit 1 set.
    function automatic logic f_supported(input logic [1:0] burst);
        return (burst & BURST_WRAP) == 2'b00;
    endfunction

    logic w_unused;
    assign w_unused = ^{ar_size, aw_size};

    logic       w_stall;
    logic [2:0] w_extra;
`ifdef AXI_SRAM_RAND_STALL_EN
    logic [7:0] w_lfsr;
    logic       w_lfsr_unused;

    axi_lfsr8 #(
        .SEED (8'hA5),
        .TAPS (8'hB8)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .i_enable (1'b1),
        .o_state  (w_lfsr)
    );

    assign w_stall       = (w_lfsr[1:0] == 2'b00);
    assign w_extra       = w_lfsr[2:0];
    assign w_lfsr_unused = ^w_lfsr[7:3];
`else
    assign w_stall = 1'b0;
    assign w_extra = 3'd0;
`endif

    // ------------------------------------------------------------------ read
    rd_state_t   r_rd_state, w_rd_state_nx;
    logic [63:0] r_rd_addr;
    logic [7:0]  r_rd_len, r_rd_beat, r_rd_cnt;
    logic [1:0]  r_rd_burst;
    logic        w_rd_load;
    logic [63:0] w_rd_beat_addr;
    logic [7:0]  w_rd_beat_num;
    logic [c_AW-1:0] w_rd_idx;

    always_ff @(posedge clock) begin
        if (reset) r_rd_state <= R_IDLE;
        else       r_rd_state <= w_rd_state_nx;
    end

    always_comb begin
        w_rd_state_nx  = r_rd_state;
        ar_ready       = 1'b0;
        r_valid        = 1'b0;
        w_rd_load      = 1'b0;
        w_rd_beat_addr = r_rd_addr;
        w_rd_beat_num  = r_rd_beat;
        case (r_rd_state)
            R_IDLE: begin
                ar_ready = !w_stall;
                if (ar_valid && !w_stall) w_rd_state_nx = R_WAIT;
            end
            R_WAIT: begin
                if (r_rd_cnt == 8'd0) begin
                    w_rd_state_nx = R_DATA;
                    w_rd_load     = 1'b1;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    if (r_rd_beat == r_rd_len) begin
                        w_rd_state_nx = R_IDLE;
                    end else begin
                        // Register the next beat on the handshake edge: no bubble.
                        w_rd_load      = 1'b1;
                        w_rd_beat_addr = next_beat_addr(r_rd_addr, r_rd_burst);
                        w_rd_beat_num  = r_rd_beat + 8'd1;
                    end
                end
            end
            default: w_rd_state_nx = R_IDLE;
        endcase
    end

    assign r_last   = r_valid && (r_rd_beat == r_rd_len);
    assign w_rd_idx = f_index(w_rd_beat_addr);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_addr  <= 64'd0;
            r_rd_len   <= 8'd0;
            r_rd_beat  <= 8'd0;
            r_rd_cnt   <= 8'd0;
            r_rd_burst <= BURST_INCR;
            r_rdata    <= 64'd0;
            r_resp     <= RESP_OKAY;
        end else begin
            if (r_rd_state == R_IDLE && ar_valid && ar_ready) begin
                r_rd_addr  <= ar_addr;
                r_rd_len   <= ar_len;
                r_rd_burst <= ar_burst;
                r_rd_beat  <= 8'd0;
                r_rd_cnt   <= c_LAT_INIT + 8'(w_extra);
            end else if (r_rd_state == R_WAIT && r_rd_cnt != 8'd0) begin
                r_rd_cnt <= r_rd_cnt - 8'd1;
            end
            if (w_rd_load) begin
                r_rd_addr <= w_rd_beat_addr;
                r_rd_beat <= w_rd_beat_num;
                if (!f_supported(r_rd_burst)) begin
                    r_rdata <= 64'd0;
                    r_resp  <= RESP_SLVERR;
                end else if (!f_in_range(w_rd_beat_addr)) begin
                    r_rdata <= 64'd0;
                    r_resp  <= RESP_DECERR;
                end else begin
                    r_rdata <= r_mem[w_rd_idx];
                    r_resp  <= RESP_OKAY;
                end
            end
        end
    end

    // ----------------------------------------------------------------- write
    wr_state_t   r_wr_state, w_wr_state_nx;
    logic [63:0] r_wr_addr;
    logic [7:0]  r_wr_len, r_wr_beat;
    logic [1:0]  r_wr_burst;
    logic        r_wr_dec, r_wr_slv;
    logic        w_w_fire, w_wr_in_range, w_wr_len_end, w_wr_end, w_wr_en;
    logic        w_dec_now, w_slv_now;
    logic [c_AW-1:0] w_wr_idx;

    assign w_wr_in_range = f_in_range(r_wr_addr);
    assign w_wr_len_end  = (r_wr_beat == r_wr_len);
    assign w_wr_end      = w_last || w_wr_len_end;
    assign w_dec_now     = r_wr_dec || !w_wr_in_range;
    assign w_slv_now     = r_wr_slv || (w_last != w_wr_len_end);
    assign w_wr_idx      = f_index(r_wr_addr);

    always_ff @(posedge clock) begin
        if (reset) r_wr_state <= W_IDLE;
        else       r_wr_state <= w_wr_state_nx;
    end

    always_comb begin
        w_wr_state_nx = r_wr_state;
        aw_ready      = 1'b0;
        w_ready       = 1'b0;
        b_valid       = 1'b0;
        w_w_fire      = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                aw_ready = !w_stall;
                if (aw_valid && !w_stall) w_wr_state_nx = W_DATA;
            end
            W_DATA: begin
                w_ready  = !w_stall;
                w_w_fire = w_valid && !w_stall;
                if (w_w_fire && w_wr_end) w_wr_state_nx = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (b_ready) w_wr_state_nx = W_IDLE;
            end
            default: w_wr_state_nx = W_IDLE;
        endcase
    end

    assign w_wr_en = w_w_fire && !reset && w_wr_in_range && f_supported(r_wr_burst);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_addr  <= 64'd0;
            r_wr_len   <= 8'd0;
            r_wr_beat  <= 8'd0;
            r_wr_burst <= BURST_INCR;
            r_wr_dec   <= 1'b0;
            r_wr_slv   <= 1'b0;
            b_resp     <= RESP_OKAY;
        end else begin
            if (r_wr_state == W_IDLE && aw_valid && aw_ready) begin
                r_wr_addr  <= aw_addr;
                r_wr_len   <= aw_len;
                r_wr_burst <= aw_burst;
                r_wr_beat  <= 8'd0;
                r_wr_dec   <= 1'b0;
                r_wr_slv   <= !f_supported(aw_burst);
            end
            if (w_w_fire) begin
                r_wr_addr <= next_beat_addr(r_wr_addr, r_wr_burst);
                r_wr_beat <= r_wr_beat + 8'd1;
                r_wr_dec  <= w_dec_now;
                r_wr_slv  <= w_slv_now;
                if (w_wr_end) begin
                    b_resp <= w_dec_now ? RESP_DECERR :
                              w_slv_now ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Same-cycle read registration sees the pre-write word.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (w_strb[i]) r_mem[w_wr_idx][i*8 +: 8] <= w_data[i*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_responder
// Description : Self-checking bench for axi_sram_responder with a word-level
//               memory model and directed plus randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_responder;

    localparam logic [63:0] BASE   = 64'h8000_0000;
    localparam int          DEPTH  = 4096;
    localparam int          RD_LAT = 2;
    localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'd8;
    localparam logic [63:0] WIN    = BASE + 64'h1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ar_valid = 1'b0, ar_ready;
    logic [63:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = 3'd3;
    logic [1:0]  ar_burst = 2'b01;
    logic        r_valid, r_ready = 1'b0, r_last;
    logic [63:0] r_rdata;
    logic [1:0]  r_resp;
    logic        aw_valid = 1'b0, aw_ready;
    logic [63:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic [2:0]  aw_size = 3'd3;
    logic [1:0]  aw_burst = 2'b01;
    logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;

    axi_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_rdata(r_rdata), .r_resp(r_resp), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    logic [63:0] mdl [int];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [1:0] burst, input int b);
        return (burst == 2'b00) ? a : a + 64'(b) * 64'd8;
    endfunction

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + SPAN);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    function automatic void exp_beat(input logic [63:0] a, input logic [1:0] burst, input int b,
                                     output logic [63:0] d, output logic [1:0] r);
        logic [63:0] ba;
        ba = beat_addr(a, burst, b);
        if (burst[1])          begin d = 64'd0; r = 2'b10; end
        else if (!in_rng(ba))  begin d = 64'd0; r = 2'b11; end
        else                   begin d = mdl[widx(ba)]; r = 2'b00; end
    endfunction

    function automatic void model_write(input logic [63:0] a, input int len, input logic [1:0] burst,
                                        input int last_at, output logic [1:0] resp);
        int n;
        bit dec, slv;
        logic [63:0] ba, word;
        n   = ((last_at < len) ? last_at : len) + 1;
        dec = 1'b0;
        slv = burst[1] || (last_at != len);
        for (int b = 0; b < n; b++) begin
            ba = beat_addr(a, burst, b);
            if (!in_rng(ba)) dec = 1'b1;
            else if (!burst[1]) begin
                word = mdl.exists(widx(ba)) ? mdl[widx(ba)] : 64'd0;
                for (int i = 0; i < 8; i++)
                    if (ws[b][i]) word[i*8 +: 8] = wd[b][i*8 +: 8];
                mdl[widx(ba)] = word;
            end
        end
        resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    task automatic do_write(input string tag, input logic [63:0] a, input int len,
                            input logic [1:0] burst, input int last_at, input bit stall);
        logic [1:0] er;
        int n, cyc;
        model_write(a, len, burst, last_at, er);
        n = ((last_at < len) ? last_at : len) + 1;
        @(negedge clock);
        aw_valid = 1'b1; aw_addr = a; aw_len = 8'(len); aw_burst = burst;
        cyc = 0;
        while (!aw_ready && cyc < 100) begin @(negedge clock); cyc++; end
        if (!aw_ready) chk({tag, "_aw_timeout"}, 64'(aw_ready), 64'd1);
        @(negedge clock);
        aw_valid = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (stall) repeat ($urandom_range(0, 2)) @(negedge clock);
            w_valid = 1'b1; w_data = wd[b]; w_strb = ws[b]; w_last = (b == last_at);
            cyc = 0;
            while (!w_ready && cyc < 100) begin @(negedge clock); cyc++; end
            if (!w_ready) chk({tag, "_w_timeout"}, 64'(w_ready), 64'd1);
            @(negedge clock);
            w_valid = 1'b0; w_last = 1'b0;
        end
        cyc = 0;
        while (!b_valid && cyc < 100) begin @(negedge clock); cyc++; end
        chk({tag, "_bvalid"}, 64'(b_valid), 64'd1);
        if (stall) repeat ($urandom_range(0, 3)) @(negedge clock);
        chk({tag, "_bresp"}, 64'(b_resp), 64'(er));
        b_ready = 1'b1;
        @(negedge clock);
        b_ready = 1'b0;
        chk({tag, "_bdone"}, 64'(b_valid), 64'd0);
    endtask

    // mode: 0 always ready, 1 ready toggles 1/0, 2 random ready
    task automatic do_read(input string tag, input logic [63:0] a, input int len,
                           input logic [1:0] burst, input int mode);
        logic [63:0] ed;
        logic [1:0]  er;
        int lat, cyc, b;
        @(negedge clock);
        ar_valid = 1'b1; ar_addr = a; ar_len = 8'(len); ar_burst = burst;
        cyc = 0;
        while (!ar_ready && cyc < 100) begin @(negedge clock); cyc++; end
        if (!ar_ready) chk({tag, "_ar_timeout"}, 64'(ar_ready), 64'd1);
        @(negedge clock);
        ar_valid = 1'b0;
        lat = 0;
        while (!r_valid && lat < 100) begin @(negedge clock); lat++; end
`ifndef AXI_SRAM_RAND_STALL_EN
        chk({tag, "_lat"}, 64'(lat), 64'(RD_LAT));
`endif
        b = 0; cyc = 0;
        while (b <= len && cyc < 1000) begin
            r_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (!r_valid) begin
                chk({tag, "_rvalid"}, 64'(r_valid), 64'd1);
                break;
            end
            exp_beat(a, burst, b, ed, er);
            chk({tag, "_data"}, r_rdata, ed);
            chk({tag, "_resp"}, 64'(r_resp), 64'(er));
            chk({tag, "_last"}, 64'(r_last), 64'(b == len));
            if (r_ready) b++;
            @(negedge clock);
            cyc++;
        end
        r_ready = 1'b0;
        chk({tag, "_rvalid_end"}, 64'(r_valid), 64'd0);
    endtask

    logic [63:0] a, ed;
    logic [1:0]  bu, er;
    int          len, start, cyc;

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_ar_ready", 64'(ar_ready), 64'd1);
        chk("rst_aw_ready", 64'(aw_ready), 64'd1);
        chk("rst_r_valid",  64'(r_valid),  64'd0);
        chk("rst_w_ready",  64'(w_ready),  64'd0);
        chk("rst_b_valid",  64'(b_valid),  64'd0);
        chk("rst_r_last",   64'(r_last),   64'd0);
        chk("rst_r_rdata",  r_rdata,       64'd0);
        chk("rst_r_resp",   64'(r_resp),   64'd0);
        chk("rst_b_resp",   64'(b_resp),   64'd0);
        reset = 1'b0;

        ws[0] = 8'hFF; wd[0] = {$urandom(), $urandom()};
        do_write("pre_base", BASE, 0, 2'b01, 0, 0);
        wd[0] = {$urandom(), $urandom()};
        do_write("pre_top", BASE + SPAN - 64'd8, 0, 2'b01, 0, 0);
        for (int i = 0; i < 64; i++) begin wd[i] = {$urandom(), $urandom()}; ws[i] = 8'hFF; end
        do_write("pre_win", WIN, 63, 2'b01, 63, 1);

        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write("single", 64'h8000_0010, 0, 2'b01, 0, 0);
        do_read("single_rd", 64'h8000_0010, 0, 2'b01, 0);

        wd[0] = '1; ws[0] = 8'hFF;
        do_write("strb_pre", 64'h8000_0018, 0, 2'b01, 0, 0);
        wd[0] = 64'd0; ws[0] = 8'h0F;
        do_write("strb", 64'h8000_0018, 0, 2'b01, 0, 0);
        do_read("strb_rd", 64'h8000_0018, 0, 2'b01, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
        do_write("incr", 64'h8000_0100, 3, 2'b01, 3, 1);
        do_read("incr_rd", 64'h8000_0100, 3, 2'b01, 1);

        for (int i = 0; i < 3; i++) begin wd[i] = {$urandom(), $urandom()}; ws[i] = 8'hFF; end
        do_write("fixed", 64'h8000_0300, 2, 2'b00, 2, 0);
        do_read("fixed_rd", 64'h8000_0300, 1, 2'b00, 2);

        do_read("oor_rd", 64'h7FFF_FFF8, 0, 2'b01, 0);
        do_read("edge_rd", BASE + SPAN - 64'd8, 1, 2'b01, 1);
        wd[0] = {$urandom(), $urandom()}; ws[0] = 8'hFF;
        do_write("oor_wr", BASE + SPAN, 0, 2'b01, 0, 0);
        do_read("oor_base_rd", BASE, 0, 2'b01, 0);

        for (int i = 0; i < 3; i++) begin wd[i] = {$urandom(), $urandom()}; ws[i] = 8'hFF; end
        do_write("proto_pre", 64'h8000_0200, 1, 2'b01, 1, 0);
        for (int i = 0; i < 3; i++) wd[i] = {$urandom(), $urandom()};
        do_write("proto", 64'h8000_0200, 2, 2'b01, 0, 0);
        do_read("proto_rd", 64'h8000_0200, 1, 2'b01, 0);
        wd[0] = {$urandom(), $urandom()};
        do_write("wrap_wr", 64'h8000_0010, 0, 2'b10, 0, 0);
        do_read("wrap_chk", 64'h8000_0010, 0, 2'b01, 0);
        do_read("wrap_rd", 64'h8000_0010, 1, 2'b10, 1);
        for (int i = 0; i < 2; i++) wd[i] = {$urandom(), $urandom()};
        do_write("nolast", WIN + 64'd80, 1, 2'b01, 999, 0);
        do_read("nolast_rd", WIN + 64'd80, 1, 2'b01, 0);

        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom(), $urandom()}; ws[i] = 8'($urandom()); end
        fork
            do_write("conc_wr", WIN + 64'd320, 7, 2'b01, 7, 1);
            do_read("conc_rd", WIN, 7, 2'b01, 2);
        join
        do_read("conc_chk", WIN + 64'd320, 7, 2'b01, 0);

        for (int it = 0; it < 30; it++) begin
            len   = $urandom_range(0, 7);
            start = $urandom_range(0, 63 - len);
            bu    = 2'($urandom_range(0, 1));
            a     = WIN + 64'(start) * 64'd8;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wd[i] = {$urandom(), $urandom()}; ws[i] = 8'($urandom()); end
                do_write("rnd_wr", a, len, bu, len, 1);
            end else begin
                do_read("rnd_rd", a, len, bu, 2);
            end
        end

        // Reset while beat 1 of a four-beat read is on the bus.
        @(negedge clock);
        ar_valid = 1'b1; ar_addr = WIN; ar_len = 8'd3; ar_burst = 2'b01;
        cyc = 0;
        while (!ar_ready && cyc < 100) begin @(negedge clock); cyc++; end
        @(negedge clock);
        ar_valid = 1'b0;
        cyc = 0;
        while (!r_valid && cyc < 100) begin @(negedge clock); cyc++; end
        r_ready = 1'b1;
        @(negedge clock);
        r_ready = 1'b0;
        exp_beat(WIN, 2'b01, 1, ed, er);
        chk("rst_mid_beat1_valid", 64'(r_valid), 64'd1);
        chk("rst_mid_beat1_data", r_rdata, ed);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_r_valid", 64'(r_valid), 64'd0);
        chk("rst_mid_ar_ready", 64'(ar_ready), 64'd1);
        reset = 1'b0;
        r_ready = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_mid_quiet", 64'(r_valid), 64'd0);
        r_ready = 1'b0;
        do_read("post_rst_rd", WIN + 64'd8, 1, 2'b01, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
